// File: rtl/sigma_iter_if.sv
// sigma_iter_if: load/stream handshake bundle for the Sigma engine.
// master drives loads and consumer ready; slave is the engine.
interface sigma_iter_if #(
  parameter int W  = 128,
  parameter int N  = 9,
  parameter int CW = $clog2(N+1)
);
  logic [W-1:0]  in_data;
  logic [CW-1:0] in_cnt;
  logic          in_mode;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_idx;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  modport master (
    output in_data, in_cnt, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_idx, out_last, out_valid, busy
  );

  modport slave (
    input  in_data, in_cnt, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_idx, out_last, out_valid, busy
  );
endinterface

// File: rtl/sigma_iter.sv
// sigma_iter: iterative CLEFIA Sigma (DoubleSwap) key-schedule engine.
// Define SIGMA_INV_EN to build the inverse datapath selected by in_mode.
module sigma_iter #(
  parameter int W = 128,
  parameter int S = 7,
  parameter int N = 9
) (
  input logic       clk,
  input logic       rst_n,
  sigma_iter_if.slave bus
);
  localparam int H  = W / 2;
  localparam int CW = $clog2(N+1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [W-1:0]  data_q;
  logic [CW-1:0] idx_q;
  logic [CW-1:0] tgt_q;
  logic          last_q;
  logic          valid_q;
`ifdef SIGMA_INV_EN
  logic          mode_q;
`endif

  logic [CW-1:0] cnt_eff;
  logic [CW:0]   idx_p2;
  logic [W-1:0]  load_nxt;
  logic [W-1:0]  run_nxt;

  function automatic logic [W-1:0] sig_fwd(input logic [W-1:0] x);
    return {x[W-S-1:H], x[S-1:0], x[W-1:W-S], x[H-1:S]};
  endfunction

`ifdef SIGMA_INV_EN
  function automatic logic [W-1:0] sig_inv(input logic [W-1:0] y);
    return {y[H-1:H-S], y[W-1:H+S], y[H-S-1:0], y[H+S-1:H]};
  endfunction
`endif

  // Clamp request count and compute next iterates for load and run paths
  always_comb begin
    cnt_eff = bus.in_cnt;
    if (bus.in_cnt == '0 || bus.in_cnt > CW'(N))
      cnt_eff = CW'(N);
    idx_p2 = {1'b0, idx_q} + (CW+1)'(2);
`ifdef SIGMA_INV_EN
    load_nxt = bus.in_mode ? sig_inv(bus.in_data)
                           : sig_fwd(bus.in_data);
    run_nxt  = mode_q ? sig_inv(data_q) : sig_fwd(data_q);
`else
    load_nxt = sig_fwd(bus.in_data);
    run_nxt  = sig_fwd(data_q);
`endif
  end

  // Load/stream FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      tgt_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef SIGMA_INV_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q  <= load_nxt;
            idx_q   <= '0;
            tgt_q   <= cnt_eff;
            last_q  <= (cnt_eff == CW'(1));
            valid_q <= 1'b1;
`ifdef SIGMA_INV_EN
            mode_q  <= bus.in_mode;
`endif
            state   <= RUN;
          end
        end
        RUN: begin
          if (valid_q && bus.out_ready) begin
            if (last_q) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              state   <= IDLE;
            end else begin
              data_q <= run_nxt;
              idx_q  <= idx_q + CW'(1);
              last_q <= (idx_p2 == {1'b0, tgt_q});
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state == RUN);
  assign bus.out_data  = data_q;
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = valid_q;
endmodule
